register_pc: RTL and testbench
==============================

// Module: register_pc
//
// PURPOSE
//   Program-counter register of the MIPS image-processing datapath. Holds the
//   current instruction address and drives it to instruction fetch. Captures
//   the next-PC value from the next-PC mux on each rising clock edge while
//   enabled; holds its value when stalled. A status flag reports addresses
//   that break the configured alignment.
//
// PARAMETERS
//   WIDTH        32            PC / address width in bits
//   RESET_VALUE  32'h0000_0000 PC value loaded on reset (boot vector)
//   ALIGN_BITS   0             number of low address bits that must be zero
//                              (0 = no alignment check; 2 = word-aligned)
//
// PORTS
//   clk        input   1      system clock; all state updates on rising edge
//   rst_n      input   1      asynchronous active-low reset
//   enable     input   1      1 = load DatoPCIN on clk edge; 0 = hold (stall)
//   DatoPCIN   input   WIDTH  next-PC value from the next-PC mux
//   DatoPCOUT  output  WIDTH  current PC, registered, to instruction fetch
//   misaligned output  1      registered; 1 when DatoPCOUT violates ALIGN_BITS
//
// BEHAVIOUR
//   - Single clock domain. One clock and one reset only.
//   - Reset: asynchronous and active-low. rst_n=0 forces
//     DatoPCOUT=RESET_VALUE and misaligned=0 immediately, independent of clk.
//     Release is synchronous in effect: the first load happens on the first
//     rising clk edge with rst_n=1.
//   - Load: on rising clk with rst_n=1 and enable=1, DatoPCOUT <= DatoPCIN.
//     Latency is 1 cycle: DatoPCIN sampled at edge N appears on DatoPCOUT
//     right after edge N. No combinational path from DatoPCIN to DatoPCOUT.
//   - Hold: enable=0 keeps DatoPCOUT and misaligned unchanged, for any number
//     of cycles.
//   - misaligned: updated on the same edge as DatoPCOUT. It is 1 when
//     ALIGN_BITS>0 and DatoPCIN[ALIGN_BITS-1:0] != 0 at the load. It is always
//     0 when ALIGN_BITS=0. The PC still loads the misaligned value; the block
//     reports the condition and does not correct it.
//   - No arithmetic is done here. Incrementing is external. The value is
//     stored bit-exact; the full WIDTH range, including all-ones, is legal.
//   - X/Z on DatoPCIN while enable=0 has no effect on outputs.
//   - Reset asserted mid-operation overrides enable and DatoPCIN at once.
//   - Reset asserted on the same edge as a load: the reset wins.
//
// TESTING
//   1. rst_n=0 with clk toggling and DatoPCIN=32'h1234 ->
//      DatoPCOUT=32'h0000_0000 and misaligned=0 throughout.
//   2. enable=1; drive DatoPCIN 0,2,4,6 on successive cycles ->
//      DatoPCOUT 0,2,4,6, each one cycle after it was driven.
//   3. DatoPCOUT=4; enable=0 for 3 cycles with DatoPCIN=8 ->
//      DatoPCOUT stays 4. Set enable=1 -> 8 on the next edge.
//   4. Drop rst_n asynchronously between edges while DatoPCOUT=6 ->
//      DatoPCOUT=RESET_VALUE before the next edge.
//   5. ALIGN_BITS=2; load 32'h0000_0006 -> misaligned=1.
//      Then load 32'h0000_0008 -> misaligned=0.
//   6. Load 32'hFFFF_FFFF then 32'h0000_0000 -> both values pass through
//      bit-exact with 1-cycle latency.

Source files
------------

// File: rtl/register_pc_if.sv
// Bus between the next-PC mux / fetch stage and the program-counter register.
interface register_pc_if #(
   parameter int unsigned WIDTH = 32
);

   logic             enable;
   logic [WIDTH-1:0] DatoPCIN;
   logic [WIDTH-1:0] DatoPCOUT;
   logic             misaligned;

   // Datapath side: supplies the next PC and the load enable, consumes the PC
   modport master (
      output enable,
      output DatoPCIN,
      input  DatoPCOUT,
      input  misaligned
   );

   // Register side
   modport slave (
      input  enable,
      input  DatoPCIN,
      output DatoPCOUT,
      output misaligned
   );

endinterface

// File: rtl/register_pc.sv
// Program-counter register: loads the next PC when enabled, holds on stall,
// and flags loaded addresses whose low ALIGN_BITS bits are not zero.
module register_pc #(
   parameter int unsigned     WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int unsigned     ALIGN_BITS  = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   register_pc_if.slave bus
);

   logic [WIDTH-1:0] pc_d, pc_q;
   logic             misaligned_d, misaligned_q;
   logic             addr_misaligned;

   // Alignment check on the incoming address; absent when ALIGN_BITS is 0
   if (ALIGN_BITS > 0) begin : g_align
      assign addr_misaligned = |bus.DatoPCIN[ALIGN_BITS-1:0];
   end else begin : g_no_align
      assign addr_misaligned = 1'b0;
   end

   // Next state: take the new PC and its alignment status only when enabled
   always_comb begin
      pc_d         = pc_q;
      misaligned_d = misaligned_q;
      if (bus.enable) begin
         pc_d         = bus.DatoPCIN;
         misaligned_d = addr_misaligned;
      end
   end

   // State register with asynchronous boot-vector reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= RESET_VALUE;
         misaligned_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign bus.DatoPCOUT  = pc_q;
   assign bus.misaligned = misaligned_q;

endmodule

// File: tb/tb_register_pc.sv
// Directed bench for register_pc: one instance word-aligned (ALIGN_BITS=2),
// one with the alignment check disabled, both driven with the same stimulus.
module tb_register_pc;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   register_pc_if #(.WIDTH(32)) bus_a ();
   register_pc_if #(.WIDTH(32)) bus_b ();

   register_pc #(
      .WIDTH      (32),
      .RESET_VALUE(32'h0000_0000),
      .ALIGN_BITS (2)
   ) u_dut_a (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus_a.slave)
   );

   register_pc #(
      .WIDTH      (32),
      .RESET_VALUE(32'h0000_0000),
      .ALIGN_BITS (0)
   ) u_dut_b (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic en, input logic [31:0] din);
      bus_a.enable   = en;
      bus_a.DatoPCIN = din;
      bus_b.enable   = en;
      bus_b.DatoPCIN = din;
   endtask

   // Advance past the next rising edge and settle
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Compare both instances: PC, and misaligned for the aligned / unaligned DUT
   task automatic check_all(input string tag, input logic [31:0] pc, input logic mis_a);
      check({tag, "_pc_a"}, bus_a.DatoPCOUT, pc);
      check({tag, "_mis_a"}, {31'd0, bus_a.misaligned}, {31'd0, mis_a});
      check({tag, "_pc_b"}, bus_b.DatoPCOUT, pc);
      check({tag, "_mis_b"}, {31'd0, bus_b.misaligned}, 32'd0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;

      // Reset held with clock running and a load pending
      rst_n = 1'b0;
      drive(1'b1, 32'h0000_1234);
      #2;
      check_all("rst_async", 32'h0, 1'b0);
      step();
      check_all("rst_edge1", 32'h0, 1'b0);
      step();
      check_all("rst_edge2", 32'h0, 1'b0);
      rst_n = 1'b1;

      // Sequential loads, one-cycle latency
      drive(1'b1, 32'h0);
      step();
      check_all("load0", 32'h0, 1'b0);
      drive(1'b1, 32'h2);
      step();
      check_all("load2", 32'h2, 1'b1);
      drive(1'b1, 32'h4);
      step();
      check_all("load4", 32'h4, 1'b0);
      drive(1'b1, 32'h6);
      step();
      check_all("load6", 32'h6, 1'b1);

      // Stall for three cycles, including an unknown input
      drive(1'b1, 32'h4);
      step();
      check_all("pre_hold", 32'h4, 1'b0);
      drive(1'b0, 32'h8);
      step();
      check_all("hold1", 32'h4, 1'b0);
      drive(1'b0, 32'h7);
      step();
      check_all("hold2", 32'h4, 1'b0);
      drive(1'b0, 32'bx);
      step();
      check_all("hold_x", 32'h4, 1'b0);
      drive(1'b1, 32'h8);
      step();
      check_all("resume8", 32'h8, 1'b0);

      // Asynchronous reset between edges
      drive(1'b1, 32'h6);
      step();
      check_all("pre_rst6", 32'h6, 1'b1);
      drive(1'b1, 32'h0000_0010);
      #2;
      rst_n = 1'b0;
      #1;
      check_all("rst_mid", 32'h0, 1'b0);
      step();
      check_all("rst_over_load", 32'h0, 1'b0);
      rst_n = 1'b1;

      // Alignment flag follows each load
      drive(1'b1, 32'h0000_0006);
      step();
      check_all("align6", 32'h6, 1'b1);
      drive(1'b1, 32'h0000_0008);
      step();
      check_all("align8", 32'h8, 1'b0);
      drive(1'b1, 32'h0000_0001);
      step();
      check_all("align1", 32'h1, 1'b1);

      // Full-range values pass through bit-exact
      drive(1'b1, 32'hFFFF_FFFF);
      step();
      check_all("all_ones", 32'hFFFF_FFFF, 1'b1);
      drive(1'b1, 32'h0000_0000);
      step();
      check_all("all_zero", 32'h0, 1'b0);
      drive(1'b1, 32'hA5A5_5A58);
      step();
      check_all("pattern", 32'hA5A5_5A58, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
